// File: rtl/mem_access_unit.sv
// mem_access_unit: bridges the MEM stage's load/store request onto a req/ack
// data bus. Steers store byte lanes, extracts and extends load data, stalls
// the pipeline while a transfer is outstanding, flags misaligned requests and
// latches a sticky error when the bus fails to acknowledge in time.
//
// state | meaning
// IDLE  | no transfer outstanding; a valid aligned request is launched
// BUSY  | bus_req held high, waiting for bus_ack or timeout
// DONE  | one cycle with stall low so the pipeline advances past the request
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] rsp_rdata,
  output logic        stall,
  output logic        misalign,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       type_q;
  logic [1:0]       off_q;

  logic             mis_raw;
  logic [3:0]       strb_c;
  logic [31:0]      wdata_c;
  logic [7:0]       byte_c;
  logic [15:0]      half_c;
  logic [31:0]      load_c;

  // Alignment check; unknown type encodings are rejected as misaligned.
  always_comb begin
    mis_raw = 1'b1;
    case (req_type)
      3'b000, 3'b100: mis_raw = 1'b0;
      3'b001, 3'b101: mis_raw = req_addr[0];
      3'b010:         mis_raw = |req_addr[1:0];
      default:        mis_raw = 1'b1;
    endcase
  end

  assign misalign = req_valid & mis_raw;
  assign stall    = ((state == IDLE) & req_valid & ~mis_raw) | (state == BUSY);

  // Store lane steering: replicate the data across the word, strobe the target lanes.
  always_comb begin
    strb_c  = 4'b1111;
    wdata_c = req_wdata;
    case (req_type[1:0])
      2'b00: begin
        strb_c  = 4'b0001 << req_addr[1:0];
        wdata_c = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        strb_c  = 4'b0011 << req_addr[1:0];
        wdata_c = {2{req_wdata[15:0]}};
      end
      default: begin
        strb_c  = 4'b1111;
        wdata_c = req_wdata;
      end
    endcase
  end

  // Load extract/extend from the registered offset and type.
  always_comb begin
    byte_c = 8'h00;
    case (off_q)
      2'd0:    byte_c = bus_rdata[7:0];
      2'd1:    byte_c = bus_rdata[15:8];
      2'd2:    byte_c = bus_rdata[23:16];
      default: byte_c = bus_rdata[31:24];
    endcase
    half_c = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    load_c = bus_rdata;
    case (type_q)
      3'b000:  load_c = {{24{byte_c[7]}}, byte_c};
      3'b001:  load_c = {{16{half_c[15]}}, half_c};
      3'b100:  load_c = {24'h0, byte_c};
      3'b101:  load_c = {16'h0, half_c};
      default: load_c = bus_rdata;
    endcase
  end

  // Transfer sequencer with registered bus fields, response and error flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      type_q    <= 3'b000;
      off_q     <= 2'b00;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_err   <= 1'b0;
      bus_addr  <= '0;
      bus_wstrb <= 4'b0000;
      bus_wdata <= '0;
      rsp_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && !mis_raw) begin
            bus_req   <= 1'b1;
            bus_we    <= req_we;
            bus_addr  <= {req_addr[31:2], 2'b00};
            bus_wstrb <= req_we ? strb_c : 4'b0000;
            bus_wdata <= req_we ? wdata_c : 32'h0;
            type_q    <= req_type;
            off_q     <= req_addr[1:0];
            cnt       <= '0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (bus_ack) begin
            bus_req   <= 1'b0;
            rsp_rdata <= load_c;
            state     <= DONE;
          end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            bus_req   <= 1'b0;
            bus_err   <= 1'b1;
            rsp_rdata <= '0;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: inputs driven and outputs sampled on the
// falling edge, expected values worked out by hand from the access rules.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_type;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] rsp_rdata;
  logic        stall;
  logic        misalign;
  logic        bus_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  mem_access_unit dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_type(req_type),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_rdata(rsp_rdata), .stall(stall), .misalign(misalign), .bus_err(bus_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Present a request in IDLE; on return the unit is in its first BUSY cycle.
  task automatic issue(input logic we, input logic [2:0] t, input logic [31:0] a,
                       input logic [31:0] wd, input string tag);
    req_valid = 1'b1; req_we = we; req_type = t; req_addr = a; req_wdata = wd;
    #1;
    chk({tag, "_stall_idle"}, 32'(stall), 32'd1);
    cyc();
    chk({tag, "_bus_req"}, 32'(bus_req), 32'd1);
  endtask

  // Acknowledge in the current BUSY cycle; on return the unit is in DONE.
  task automatic ack(input logic [31:0] rd, input string tag);
    bus_ack = 1'b1; bus_rdata = rd;
    cyc();
    bus_ack = 1'b0; bus_rdata = 32'h0;
    chk({tag, "_done_req"}, 32'(bus_req), 32'd0);
    chk({tag, "_done_stall"}, 32'(stall), 32'd0);
    cyc();
    req_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_type = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
    cyc(); cyc();
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_wstrb", 32'(bus_wstrb), 32'h0);
    chk("rst_stall", 32'(stall), 32'd0);
    rst_n = 1'b1;
    cyc();

    // SW 0xDEADBEEF @0x100, ack in first BUSY cycle
    issue(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, "sw");
    chk("sw_stall_busy", 32'(stall), 32'd1);
    chk("sw_we", 32'(bus_we), 32'd1);
    chk("sw_addr", bus_addr, 32'h100);
    chk("sw_wstrb", 32'(bus_wstrb), 32'hF);
    chk("sw_wdata", bus_wdata, 32'hDEADBEEF);
    ack(32'h0, "sw");

    // LB @0x103
    issue(1'b0, 3'b000, 32'h103, 32'h0, "lb");
    chk("lb_we", 32'(bus_we), 32'd0);
    chk("lb_wstrb", 32'(bus_wstrb), 32'h0);
    chk("lb_addr", bus_addr, 32'h100);
    ack(32'h80FF_1234, "lb");
    chk("lb_rdata", rsp_rdata, 32'hFFFF_FF80);

    // LBU @0x103, acked after three BUSY cycles
    issue(1'b0, 3'b100, 32'h103, 32'h0, "lbu");
    cyc(); cyc();
    chk("lbu_stall_hold", 32'(stall), 32'd1);
    chk("lbu_req_hold", 32'(bus_req), 32'd1);
    ack(32'h80FF_1234, "lbu");
    chk("lbu_rdata", rsp_rdata, 32'h0000_0080);

    // SH 0xABCD @0x102
    issue(1'b1, 3'b001, 32'h102, 32'h0000_ABCD, "sh");
    chk("sh_addr", bus_addr, 32'h100);
    chk("sh_wstrb", 32'(bus_wstrb), 32'hC);
    chk("sh_wdata", bus_wdata, 32'hABCDABCD);
    ack(32'h0, "sh");

    // SB 0x5A @0x101
    issue(1'b1, 3'b000, 32'h101, 32'h0000_005A, "sb");
    chk("sb_wstrb", 32'(bus_wstrb), 32'h2);
    chk("sb_wdata", bus_wdata, 32'h5A5A5A5A);
    ack(32'h0, "sb");

    // LHU @0x102
    issue(1'b0, 3'b101, 32'h102, 32'h0, "lhu");
    ack(32'hABCD_0000, "lhu");
    chk("lhu_rdata", rsp_rdata, 32'h0000_ABCD);

    // LH @0x100 sign-extends the low half
    issue(1'b0, 3'b001, 32'h100, 32'h0, "lh");
    ack(32'h1234_8001, "lh");
    chk("lh_rdata", rsp_rdata, 32'hFFFF_8001);

    // Misaligned LW @0x101: no transfer, no stall, rsp unchanged
    req_valid = 1'b1; req_we = 1'b0; req_type = 3'b010; req_addr = 32'h101;
    #1;
    chk("lw_mis_flag", 32'(misalign), 32'd1);
    chk("lw_mis_stall", 32'(stall), 32'd0);
    cyc();
    chk("lw_mis_req", 32'(bus_req), 32'd0);
    chk("lw_mis_rdata", rsp_rdata, 32'hFFFF_8001);
    req_type = 3'b001; req_addr = 32'h103;
    #1;
    chk("lh_mis_flag", 32'(misalign), 32'd1);
    req_type = 3'b011; req_addr = 32'h100;
    #1;
    chk("illegal_flag", 32'(misalign), 32'd1);
    chk("illegal_stall", 32'(stall), 32'd0);
    cyc();
    chk("illegal_req", 32'(bus_req), 32'd0);
    req_valid = 1'b0;

    // Stray ack in IDLE is ignored
    bus_ack = 1'b1; bus_rdata = 32'h5555_5555;
    cyc();
    bus_ack = 1'b0; bus_rdata = 32'h0;
    chk("idle_ack_rdata", rsp_rdata, 32'hFFFF_8001);

    // Timeout: LW @0x200 never acknowledged, 256 BUSY cycles
    issue(1'b0, 3'b010, 32'h200, 32'h0, "to");
    for (int i = 0; i < 255; i++) cyc();
    chk("to_last_busy_req", 32'(bus_req), 32'd1);
    chk("to_last_busy_err", 32'(bus_err), 32'd0);
    chk("to_last_busy_stall", 32'(stall), 32'd1);
    cyc();
    chk("to_err", 32'(bus_err), 32'd1);
    chk("to_rdata", rsp_rdata, 32'h0);
    chk("to_stall", 32'(stall), 32'd0);
    chk("to_req", 32'(bus_req), 32'd0);
    cyc();
    req_valid = 1'b0;
    cyc();
    chk("to_err_sticky", 32'(bus_err), 32'd1);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk("to_err_cleared", 32'(bus_err), 32'd0);

    // Load a nonzero result, then reset mid-BUSY followed by a late ack
    issue(1'b0, 3'b010, 32'h300, 32'h0, "lw");
    ack(32'h2468_ACE0, "lw");
    chk("lw_rdata", rsp_rdata, 32'h2468_ACE0);
    issue(1'b0, 3'b010, 32'h304, 32'h0, "rb");
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1; req_valid = 1'b0;
    bus_ack = 1'b1; bus_rdata = 32'h1111_1111;
    cyc();
    bus_ack = 1'b0; bus_rdata = 32'h0;
    chk("rb_req", 32'(bus_req), 32'd0);
    chk("rb_rdata", rsp_rdata, 32'h0);
    chk("rb_stall", 32'(stall), 32'd0);
    issue(1'b0, 3'b010, 32'h308, 32'h0, "post");
    ack(32'h0BAD_F00D, "post");
    chk("post_rdata", rsp_rdata, 32'h0BAD_F00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
